tl_intersection_ctrl: RTL

Parametrised multi-approach traffic-light controller for the board's lamp outputs, driven from the 24 MHz system clock. It cycles green, yellow and all-red clearance across NUM_DIR approaches in round-robin order, with durations set in seconds. It adds a latched pedestrian walk phase and a night flashing-yellow mode. It sits directly between the board pushbutton/switch inputs and the LED pins.

---
 rtl/tl_pkg.sv | 29 ++
 rtl/tl_sec_tick.sv | 35 +++
 rtl/tl_intersection_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared types and helpers for the intersection controller
// Contents:
//   tl_state_t : controller phases (ALL_RED, GREEN, YELLOW, WALK, FLASH)
//   LAMP_R/Y/G : row index of each lamp colour in the packed lamp register
//   cnt_w      : counter width able to hold 0..n-1 (never below 1 bit)
//   max2       : larger of two integers, for parameter arithmetic
package tl_pkg;

   typedef enum logic [2:0] {
      ST_ALL_RED = 3'd0,
      ST_GREEN   = 3'd1,
      ST_YELLOW  = 3'd2,
      ST_WALK    = 3'd3,
      ST_FLASH   = 3'd4
   } tl_state_t;

   localparam int LAMP_R = 0;
   localparam int LAMP_Y = 1;
   localparam int LAMP_G = 2;

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tl_sec_tick.sv
// rtl/tl_sec_tick.sv - one-second prescaler with synchronous clear
// Ports:
//   sys_clk   in  clock
//   sys_rst_n in  asynchronous active-low reset
//   clr       in  synchronous clear, restarts the second from zero
//   sec_tick  out one-cycle pulse on the last cycle of each second
module tl_sec_tick
   import tl_pkg::*;
#(
   parameter int CLK_HZ = 24_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic clr,
   output logic sec_tick
);

   localparam int PW = cnt_w(CLK_HZ);
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/tl_intersection_ctrl.sv
// rtl/tl_intersection_ctrl.sv - round-robin traffic-light controller with walk and night flash
// Optional feature: TL_NIGHT_FLASH_EN enables the night_mode input and the FLASH phase.
// Ports:
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   ped_req               async pedestrian pushbutton (synchronised, rising edge latched)
//   night_mode            async night switch (ignored without TL_NIGHT_FLASH_EN)
//   lamp_r/lamp_y/lamp_g  per-approach lamps, registered
//   walk                  pedestrian walk lamp
//   ped_pending           latched request not yet served
//   cur_dir               approach owning green/yellow
module tl_intersection_ctrl
   import tl_pkg::*;
#(
   parameter int CLK_HZ    = 24_000_000,
   parameter int NUM_DIR   = 2,
   parameter int GREEN_S   = 5,
   parameter int YELLOW_S  = 2,
   parameter int ALL_RED_S = 1,
   parameter int WALK_S    = 4
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic                        ped_req,
   input  logic                        night_mode,
   output logic [NUM_DIR-1:0]          lamp_r,
   output logic [NUM_DIR-1:0]          lamp_y,
   output logic [NUM_DIR-1:0]          lamp_g,
   output logic                        walk,
   output logic                        ped_pending,
   output logic [cnt_w(NUM_DIR)-1:0]   cur_dir
);

   localparam int DW    = cnt_w(NUM_DIR);
   localparam int MAX_S = max2(max2(GREEN_S, YELLOW_S), max2(ALL_RED_S, WALK_S));
   localparam int SW    = cnt_w(MAX_S);
   localparam logic [SW-1:0] G_LAST = SW'(GREEN_S - 1);
   localparam logic [SW-1:0] Y_LAST = SW'(YELLOW_S - 1);
   localparam logic [SW-1:0] A_LAST = SW'(ALL_RED_S - 1);
   localparam logic [SW-1:0] W_LAST = SW'(WALK_S - 1);
   localparam logic [DW-1:0] DIR_LAST = DW'(NUM_DIR - 1);

   tl_state_t                   state, state_nxt;
   logic [DW-1:0]               dir, dir_nxt, dir_inc;
   logic [SW-1:0]               sec_cnt, sec_cnt_nxt, last_sec;
   logic [2:0][NUM_DIR-1:0]     lamp_q, lamp_nxt;
   logic [NUM_DIR-1:0]          dir_oh;
   logic                        walk_q, walk_nxt, ped_nxt;
   logic [1:0]                  ped_sync;
   logic                        ped_prev, ped_edge, night_s;
   logic                        state_chg, sec_tick, dur_done;

   // Input synchronisers; the edge detector runs on the synchronised level.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ped_sync <= '0;
         ped_prev <= 1'b0;
      end else begin
         ped_sync <= {ped_sync[0], ped_req};
         ped_prev <= ped_sync[1];
      end
   end
   assign ped_edge = ped_sync[1] & ~ped_prev;

`ifdef TL_NIGHT_FLASH_EN
   logic [1:0] night_sync;
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) night_sync <= '0;
      else            night_sync <= {night_sync[0], night_mode};
   end
   assign night_s = night_sync[1];
`else
   logic night_unused;
   assign night_unused = night_mode;
   assign night_s      = 1'b0;
`endif

   // Any state change restarts the second; FLASH keeps it free-running for the blink.
   tl_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (state_chg),
      .sec_tick  (sec_tick)
   );

   assign dir_inc = (dir == DIR_LAST) ? '0 : dir + 1'b1;

   always_comb begin
      case (state)
         ST_GREEN:  last_sec = G_LAST;
         ST_YELLOW: last_sec = Y_LAST;
         ST_WALK:   last_sec = W_LAST;
         default:   last_sec = A_LAST;
      endcase
      dur_done = sec_tick && (sec_cnt == last_sec);
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      case (state)
         ST_ALL_RED: if (dur_done) begin
            if (night_s)          state_nxt = ST_FLASH;
            else if (ped_pending) state_nxt = ST_WALK;
            else begin
               state_nxt = ST_GREEN;
               dir_nxt   = dir_inc;
            end
         end
         // Night aborts green at once; yellow still runs its full time.
         ST_GREEN:  if (night_s || dur_done) state_nxt = ST_YELLOW;
         ST_YELLOW: if (dur_done) state_nxt = ST_ALL_RED;
         ST_WALK:   if (dur_done) begin
            if (night_s) state_nxt = ST_FLASH;
            else begin
               state_nxt = ST_GREEN;
               dir_nxt   = dir_inc;
            end
         end
`ifdef TL_NIGHT_FLASH_EN
         // Leaving night hands the next green to approach 0.
         ST_FLASH:  if (!night_s) begin
            state_nxt = ST_ALL_RED;
            dir_nxt   = DIR_LAST;
         end
`endif
         default: begin
            state_nxt = ST_ALL_RED;
            dir_nxt   = DIR_LAST;
         end
      endcase
   end

   // Counter, request latch and lamp decode of the next state.
   always_comb begin
      state_chg = (state_nxt != state);
      dir_oh    = NUM_DIR'(1) << dir_nxt;

      sec_cnt_nxt = sec_cnt;
      if (state_chg)                            sec_cnt_nxt = '0;
      else if (sec_tick && state != ST_FLASH)   sec_cnt_nxt = sec_cnt + 1'b1;

      // A request arriving on the ALL_RED exit edge is kept for the next round.
      ped_nxt = ped_pending;
      if (ped_edge && (state == ST_GREEN || state == ST_YELLOW || state == ST_ALL_RED))
         ped_nxt = 1'b1;
      if (state_chg && (state_nxt == ST_WALK || state_nxt == ST_FLASH))
         ped_nxt = 1'b0;

      lamp_nxt = '0;
      walk_nxt = 1'b0;
      case (state_nxt)
         ST_GREEN: begin
            lamp_nxt[LAMP_G] = dir_oh;
            lamp_nxt[LAMP_R] = ~dir_oh;
         end
         ST_YELLOW: begin
            lamp_nxt[LAMP_Y] = dir_oh;
            lamp_nxt[LAMP_R] = ~dir_oh;
         end
         ST_WALK: begin
            lamp_nxt[LAMP_R] = '1;
            walk_nxt         = 1'b1;
         end
`ifdef TL_NIGHT_FLASH_EN
         ST_FLASH: begin
            if (state != ST_FLASH) lamp_nxt[LAMP_Y] = '1;
            else if (sec_tick)     lamp_nxt[LAMP_Y] = ~lamp_q[LAMP_Y];
            else                   lamp_nxt[LAMP_Y] = lamp_q[LAMP_Y];
         end
`endif
         default: lamp_nxt[LAMP_R] = '1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state            <= ST_ALL_RED;
         dir              <= DIR_LAST;
         sec_cnt          <= '0;
         ped_pending      <= 1'b0;
         lamp_q           <= '0;
         lamp_q[LAMP_R]   <= '1;
         walk_q           <= 1'b0;
      end else begin
         state       <= state_nxt;
         dir         <= dir_nxt;
         sec_cnt     <= sec_cnt_nxt;
         ped_pending <= ped_nxt;
         lamp_q      <= lamp_nxt;
         walk_q      <= walk_nxt;
      end
   end

   assign lamp_r  = lamp_q[LAMP_R];
   assign lamp_y  = lamp_q[LAMP_Y];
   assign lamp_g  = lamp_q[LAMP_G];
   assign walk    = walk_q;
   assign cur_dir = dir;

endmodule
